// File: rtl/sdram_burst_responder_pkg.sv
// Shared types for the SDRAM burst responder: command encoding, FSM states
// and the byte-enabled write payload of the internal word array.
package sdram_burst_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic {
    MEM_CMD_READ  = 1'b0,
    MEM_CMD_WRITE = 1'b1
  } MemCmd;

  typedef enum logic [2:0] {
    RSP_INIT      = 3'd0,
    RSP_IDLE      = 3'd1,
    RSP_WRITE     = 3'd2,
    RSP_READ_WAIT = 3'd3,
    RSP_READ      = 3'd4
  } ResponderState;

  typedef struct packed {
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
  } mem_wr_t;

  // The interface mask marks bytes to keep; the array wants bytes to write.
  function automatic logic [BE_W-1:0] mask_to_be(input logic [BE_W-1:0] mask);
    return ~mask;
  endfunction

endpackage

// File: rtl/responder_mem_array.sv
// Single-port 32-bit word array with per-byte write enable and a registered
// (read-first) output; shaped so it maps onto block RAM.
module responder_mem_array
  import sdram_burst_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  mem_wr_t           i_wr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(BE_W); b++) begin
      if (i_wr.be[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wr.data[8*b +: 8];
      end
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/sdram_burst_responder.sv
// Memory-side stand-in for the SDRAM controller: accepts single-cycle burst
// commands, stores writes in a local array and replays fixed-latency read bursts.
module sdram_burst_responder
  import sdram_burst_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 21,
  parameter int unsigned MEM_DEPTH_LOG2 = 12,
  parameter int unsigned BURST_BEATS    = 8,
  parameter int unsigned READ_LATENCY   = 4,
  parameter int unsigned INIT_CYCLES    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  cmd,
  input  logic                  cmd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [BE_W-1:0]       data_mask,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_data_valid,
  output logic                  busy,
  output logic                  error
);

  localparam int unsigned PTR_W  = MEM_DEPTH_LOG2;
  localparam int unsigned BEAT_W = $clog2(BURST_BEATS + 1);
  localparam int unsigned LAT_W  = $clog2(READ_LATENCY + 1);
  localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  // With the minimum latency, beat 0 is fetched straight off the input address.
  localparam logic [PTR_W-1:0] RD_PTR_LEAD = PTR_W'((READ_LATENCY == 2) ? 1 : 0);

  if (READ_LATENCY < 2) begin : g_bad_read_latency
    $error("sdram_burst_responder: READ_LATENCY must be at least 2");
  end
  if (BURST_BEATS < 2) begin : g_bad_burst_beats
    $error("sdram_burst_responder: BURST_BEATS must be at least 2");
  end
  if (ADDR_WIDTH < MEM_DEPTH_LOG2) begin : g_bad_addr_width
    $error("sdram_burst_responder: ADDR_WIDTH must cover MEM_DEPTH_LOG2");
  end

  ResponderState     r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [BEAT_W-1:0] r_beat;
  logic [LAT_W-1:0]  r_lat;
  logic [INIT_W-1:0] r_init;

  logic [PTR_W-1:0]  w_addr_lo;
  logic [PTR_W-1:0]  w_ram_addr;
  mem_wr_t           w_ram_wr;
  logic [DATA_W-1:0] w_ram_q;
  logic              w_accept;
  logic              w_is_write;
  logic              w_rd_issue;
  logic              w_unused_addr;

  assign w_addr_lo     = addr[PTR_W-1:0];
  assign w_unused_addr = ^addr;
  assign w_accept      = cmd_en && (r_state == RSP_IDLE);
  assign w_is_write    = (MemCmd'(cmd) == MEM_CMD_WRITE);
  // Array reads run one cycle ahead of each emitted beat.
  assign w_rd_issue    = (32'(r_lat) + 32'd3) >= READ_LATENCY;

  // Array port steering: live address while idle, burst pointer otherwise.
  always_comb begin
    w_ram_addr    = r_ptr;
    w_ram_wr.be   = '0;
    w_ram_wr.data = wr_data;
    if (r_state == RSP_IDLE) begin
      w_ram_addr = w_addr_lo;
    end
    if (!rst && ((w_accept && w_is_write) || (r_state == RSP_WRITE))) begin
      w_ram_wr.be = mask_to_be(data_mask);
    end
  end

  responder_mem_array #(
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_addr  (w_ram_addr),
    .i_wr    (w_ram_wr),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RSP_INIT;
      r_ptr         <= '0;
      r_beat        <= '0;
      r_lat         <= '0;
      r_init        <= '0;
      init_done     <= 1'b0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      busy          <= 1'b1;
      error         <= 1'b0;
    end else begin
      // Any strobe outside IDLE is dropped and flagged; the burst carries on.
      if (cmd_en && (r_state != RSP_IDLE)) begin
        error <= 1'b1;
      end

      case (r_state)
        RSP_INIT: begin
          if (r_init == INIT_W'(INIT_CYCLES - 1)) begin
            r_state   <= RSP_IDLE;
            init_done <= 1'b1;
            busy      <= 1'b0;
          end else begin
            r_init <= r_init + INIT_W'(1);
          end
        end

        RSP_IDLE: begin
          if (cmd_en) begin
            busy <= 1'b1;
            if (w_is_write) begin
              r_state <= RSP_WRITE;
              r_ptr   <= w_addr_lo + PTR_W'(1);
              r_beat  <= BEAT_W'(1);
            end else begin
              r_state <= RSP_READ_WAIT;
              r_ptr   <= w_addr_lo + RD_PTR_LEAD;
              r_lat   <= '0;
            end
          end
        end

        RSP_WRITE: begin
          r_ptr <= r_ptr + PTR_W'(1);
          if (r_beat == BEAT_W'(BURST_BEATS - 1)) begin
            r_state <= RSP_IDLE;
            busy    <= 1'b0;
          end else begin
            r_beat <= r_beat + BEAT_W'(1);
          end
        end

        RSP_READ_WAIT: begin
          if (w_rd_issue) begin
            r_ptr <= r_ptr + PTR_W'(1);
          end
          if (r_lat == LAT_W'(READ_LATENCY - 2)) begin
            rd_data       <= w_ram_q;
            rd_data_valid <= 1'b1;
            r_beat        <= BEAT_W'(1);
            r_state       <= RSP_READ;
          end else begin
            r_lat <= r_lat + LAT_W'(1);
          end
        end

        RSP_READ: begin
          r_ptr <= r_ptr + PTR_W'(1);
          if (r_beat == BEAT_W'(BURST_BEATS)) begin
            rd_data_valid <= 1'b0;
            busy          <= 1'b0;
            r_state       <= RSP_IDLE;
          end else begin
            rd_data <= w_ram_q;
            r_beat  <= r_beat + BEAT_W'(1);
          end
        end

        default: begin
          r_state <= RSP_INIT;
        end
      endcase
    end
  end

endmodule

// File: doc/sdram_burst_responder.md
# sdram_burst_responder

Synthesizable memory-side responder for the frame buffer's command/burst interface, used to stand in for the SDRAM controller in simulation and on-chip loopback tests. It accepts single-cycle read/write commands from `VideoController`, stores data in an internal block-RAM array, and returns read bursts with the fixed latency and beat count the frame buffer expects. It sits where the Gowin SDRAM controller IP normally sits, on the `fb_clk` domain.

## Interface
Parameters:
- `ADDR_WIDTH`, 21, width of `addr` (word address).
- `MEM_DEPTH_LOG2`, 12, internal array holds 2^MEM_DEPTH_LOG2 32-bit words; addresses wrap modulo depth.
- `BURST_BEATS`, 8, data beats per read or write burst.
- `READ_LATENCY`, 4, cycles from the accepted read command to the first `rd_data_valid`.
- `INIT_CYCLES`, 16, cycles after reset release before `init_done` rises.

Ports:
- `clk`  in  1  fabric clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `init_done`  out  1  high once initialization completes; stays high until reset.
- `cmd`  in  1  0 = read, 1 = write; sampled with `cmd_en`.
- `cmd_en`  in  1  single-cycle command strobe.
- `addr`  in  ADDR_WIDTH  burst start word address.
- `wr_data`  in  32  write beat data.
- `data_mask`  in  4  per-byte mask; bit=1 means the byte is NOT written.
- `rd_data`  out  32  read beat data.
- `rd_data_valid`  out  1  qualifies `rd_data`.
- `busy`  out  1  high whenever a new command would be rejected.
- `error`  out  1  sticky protocol-violation flag.

## Operation
- States: INIT, IDLE, WRITE, READ_WAIT, READ.
- Reset: state=INIT; counters=0; `init_done`=0, `rd_data`=0, `rd_data_valid`=0, `busy`=1, `error`=0. Memory contents are not cleared.
- INIT: count INIT_CYCLES cycles, then go to IDLE with `init_done`=1 and `busy`=0.
- IDLE and `cmd_en`=1 and `cmd`=1: write beat 0 (`wr_data` at `addr`, masked) in that same edge, then go to WRITE. WRITE consumes beats 1..BURST_BEATS-1 on consecutive cycles at addr+i; `cmd_en` is ignored during WRITE. After the last beat, return to IDLE.
- IDLE and `cmd_en`=1 and `cmd`=0: latch addr, go to READ_WAIT, then READ. READ emits BURST_BEATS consecutive beats of words addr+0..addr+BURST_BEATS-1, then returns to IDLE.
- Addresses: beat address = (addr + i) mod 2^MEM_DEPTH_LOG2. Upper address bits are ignored. A burst crossing the top of memory wraps to word 0.
- `error` is set if `cmd_en`=1 while `busy`=1 (in INIT, WRITE, READ_WAIT or READ). The offending command is dropped and the current burst continues unaffected. `error` clears only on reset.
- Reset mid-burst aborts immediately: `rd_data_valid` drops on the next edge. Words already written remain in memory.

## Timing
- A command is accepted on edge T (IDLE, `cmd_en`=1).
- Write: beats are sampled on edges T..T+BURST_BEATS-1. `busy` is high on T+1..T+BURST_BEATS-1. A new command can be accepted at T+BURST_BEATS (back-to-back, no turnaround).
- Read: `rd_data_valid`=1 on cycles T+READ_LATENCY..T+READ_LATENCY+BURST_BEATS-1, beat i on cycle T+READ_LATENCY+i. Defaults: valid on cycles T+4..T+11.
- Read `busy` is high from T+1 through T+READ_LATENCY+BURST_BEATS-1. The next command is accepted at T+READ_LATENCY+BURST_BEATS.
- The memory read is synchronous: issue the array address one cycle ahead of each beat. `rd_data`/`rd_data_valid` are registered outputs. `rd_data` holds its last beat value when not valid.
- Read-after-write: a read accepted right after a write's last beat returns the new data, since the write completes before the read's first array access.
- READ_LATENCY must be ≥2. Smaller values are illegal; check this with a generate-time assertion.

## Structure
- Add to shared package `FrameUploaderTypes`: `MemCmd` enum (`MEM_CMD_READ`=0, `MEM_CMD_WRITE`=1) and `ResponderState` enum for the five states.
- One sub-module, `responder_mem_array`: a single-port 32-bit RAM, 2^MEM_DEPTH_LOG2 deep, with a 4-bit byte write enable and synchronous read. It infers Gowin BSRAM.
- Top level: state machine, beat counter (clog2(BURST_BEATS)), latency counter, address incrementer, and error logic.

## Test plan
- Reset, then hold `cmd_en`=0 → `init_done` rises exactly 16 cycles after `rst` falls; `busy`=1 before that, 0 after.
- Write burst at addr 0x000100 with data 0xA0000000+i, mask 0, then read 0x000100 → `rd_data_valid` on cycles T+4..T+11, values 0xA0000000..0xA0000007 in order.
- Write 0xFFFFFFFF to 0x10, then write 0x12345678 to 0x10 with `data_mask`=4'b1010 (all 8 beats) → reading 0x10 returns 0xFF34FF78.
- Wrap: write burst at 0xFFE (depth 4096) → a read at 0x000 returns beats 2..7 in its first six words; a read at 0x1FFE (upper bits ignored) returns all 8 written beats.
- Pulse `cmd_en` at T+2 during a read burst → `error`=1 stays set, the original 8 beats are delivered intact, no extra burst occurs; the next legal command at T+12 is accepted.
- Assert `rst` at beat 3 of a read → `rd_data_valid`=0 on the next edge, `init_done`=0, `error`=0; after re-init, previously written data is still readable.
